// File: rtl/reg_file_writeback_pkg.sv
// Shared widths, register index constants and reset values for the
// write-back / register file slice of the single-cycle datapath.
package reg_file_writeback_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam logic [31:0] SP_RESET_DEF = 32'h0000_0FFC;

endpackage

// File: rtl/reg_file_writeback_wb_select.sv
// Write-back muxes: destination index (rt/rd) and write-back value
// (ALU result or load data). Purely combinational.
module wb_select
    import reg_file_writeback_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  RegDst,
    input  logic                  MemtoReg,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] ALU_Result,
    input  logic [DATA_WIDTH-1:0] Mem_Read_Data,
    output logic [ADDR_WIDTH-1:0] WB_Addr,
    output logic [DATA_WIDTH-1:0] WB_Data
);

    // Destination and data selection
    always_comb begin
        WB_Addr = rt_addr;
        WB_Data = ALU_Result;
        if (RegDst) begin
            WB_Addr = rd_addr;
        end else begin
            WB_Addr = rt_addr;
        end
        if (MemtoReg) begin
            WB_Data = Mem_Read_Data;
        end else begin
            WB_Data = ALU_Result;
        end
    end

endmodule

// File: rtl/reg_file_writeback.sv
// 32-entry register file with folded-in write-back selection, optional
// same-cycle write-to-read bypass, and a committed-write counter.
module reg_file_writeback
    import reg_file_writeback_pkg::*;
#(
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int                    SP_INDEX   = 29,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = SP_RESET_DEF,
    parameter bit                    BYPASS_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWrite,
    input  logic                  RegDst,
    input  logic                  MemtoReg,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] ALU_Result,
    input  logic [DATA_WIDTH-1:0] Mem_Read_Data,
    output logic [DATA_WIDTH-1:0] Reg_File_RD1,
    output logic [DATA_WIDTH-1:0] Reg_File_RD2,
    output logic [DATA_WIDTH-1:0] WB_Data,
    output logic [ADDR_WIDTH-1:0] WB_Addr,
    output logic [15:0]           wr_count
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [15:0]           wr_count_r;
    logic [ADDR_WIDTH-1:0] wb_addr_s;
    logic [DATA_WIDTH-1:0] wb_data_s;
    logic                  wr_en_s;

    wb_select #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_wb_select (
        .RegDst       (RegDst),
        .MemtoReg     (MemtoReg),
        .rt_addr      (rt_addr),
        .rd_addr      (rd_addr),
        .ALU_Result   (ALU_Result),
        .Mem_Read_Data(Mem_Read_Data),
        .WB_Addr      (wb_addr_s),
        .WB_Data      (wb_data_s)
    );

    // Index 0 is hardwired, so writes to it neither commit nor count
    always_comb begin
        wr_en_s = 1'b0;
        if (RegWrite && (wb_addr_s != {ADDR_WIDTH{1'b0}})) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Register array: async reset loads SP, clears everything else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == SP_INDEX) begin
                    regs_r[i] <= SP_RESET;
                end else begin
                    regs_r[i] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else if (wr_en_s) begin
            regs_r[wb_addr_s] <= wb_data_s;
        end
    end

    // Committed-write counter, wraps silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count_r <= 16'd0;
        end else if (wr_en_s) begin
            wr_count_r <= wr_count_r + 16'd1;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic                  wen,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] value;
        if (addr == {ADDR_WIDTH{1'b0}}) begin
            value = {DATA_WIDTH{1'b0}};
        end else if (BYPASS_EN && wen && (addr == waddr)) begin
            value = wdata;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    // Zero-latency read ports with optional bypass
    always_comb begin
        Reg_File_RD1 = read_port(rs_addr, wb_addr_s, wr_en_s, wb_data_s, regs_r[rs_addr]);
        Reg_File_RD2 = read_port(rt_addr, wb_addr_s, wr_en_s, wb_data_s, regs_r[rt_addr]);
    end

    assign WB_Addr  = wb_addr_s;
    assign WB_Data  = wb_data_s;
    assign wr_count = wr_count_r;

endmodule
